// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Sizes here are defaults only; instances override them through parameters.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 2;

  // Register count for a given index width. Every index value is a real register.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Busy bit per register: issue sets it, writeback clears it.
// A same-edge issue beats a writeback, because the newer producer is still in flight.
module rf_busy_table
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = rf_depth(ADDR_W)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRD,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RD,
  output logic [DEPTH-1:0]  BusyMask
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_issueDec;
  logic [DEPTH-1:0] w_writeDec;
  logic [DEPTH-1:0] w_busyNext;

  // Clear on writeback first, then set on issue, so issue has priority.
  always_comb begin
    w_issueDec = IssueValid ? (DEPTH'(1) << IssueRD) : '0;
    w_writeDec = RegWrite   ? (DEPTH'(1) << RD)      : '0;
    w_busyNext = (r_busy & ~w_writeDec) | w_issueDec;
    if (ZERO_REG != 0) begin
      w_busyNext[0] = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign BusyMask = r_busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with optional hardwired R0, write-to-read bypass,
// and a per-register busy scoreboard that decode uses to stall on pending sources.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = rf_depth(ADDR_W)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRD,
  output logic              BusyRS,
  output logic              BusyRT,
  output logic [DEPTH-1:0]  BusyMask
);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busyMask;
  logic              w_writeEn;
  logic [DATA_W-1:0] w_readRs;
  logic [DATA_W-1:0] w_readRt;
  logic              w_busyRs;
  logic              w_busyRt;

  assign w_writeEn = RegWrite && !((ZERO_REG != 0) && (RD == '0));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeEn) begin
      r_regs[RD] <= WriteData;
    end
  end

  rf_busy_table #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busyTable (
    .Clock      (Clock),
    .Reset      (Reset),
    .IssueValid (IssueValid),
    .IssueRD    (IssueRD),
    .RegWrite   (RegWrite),
    .RD         (RD),
    .BusyMask   (w_busyMask)
  );

  // A forwarded write also hides the busy bit, since the value is already here.
  always_comb begin
    w_readRs = r_regs[RS];
    w_busyRs = w_busyMask[RS];
    if ((BYPASS != 0) && RegWrite && (RD == RS)) begin
      w_readRs = WriteData;
      w_busyRs = 1'b0;
    end
    if ((ZERO_REG != 0) && (RS == '0)) begin
      w_readRs = '0;
    end

    w_readRt = r_regs[RT];
    w_busyRt = w_busyMask[RT];
    if ((BYPASS != 0) && RegWrite && (RD == RT)) begin
      w_readRt = WriteData;
      w_busyRt = 1'b0;
    end
    if ((ZERO_REG != 0) && (RT == '0)) begin
      w_readRt = '0;
    end
  end

  // Reset also masks the bypass path so nothing leaks out while it is held.
  assign ReadRS   = Reset ? '0 : w_readRs;
  assign ReadRT   = Reset ? '0 : w_readRt;
  assign BusyRS   = Reset ? 1'b0 : w_busyRs;
  assign BusyRT   = Reset ? 1'b0 : w_busyRt;
  assign BusyMask = Reset ? '0 : w_busyMask;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 4x16 CPU register file.
- Configurable width and depth, optional hardwired-zero R0, and write-to-read bypass.
- Per-register busy scoreboard: set when a multi-cycle producer issues, cleared on writeback.
- Sits between decode (read ports, issue) and writeback (write port); decode stalls on busy sources.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 2, register index width; depth = 2**ADDR_W.
- ZERO_REG, 0, when 1: R0 reads 0 and ignores writes and issues.
- BYPASS, 1, when 1: a same-cycle write is forwarded to the read ports and clears the matching busy outputs.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- RS  in  ADDR_W  read port A index.
- RT  in  ADDR_W  read port B index.
- ReadRS  out  DATA_W  read port A data, combinational.
- ReadRT  out  DATA_W  read port B data, combinational.
- RD  in  ADDR_W  write index.
- WriteData  in  DATA_W  write data.
- RegWrite  in  1  write enable, sampled at posedge Clock.
- IssueValid  in  1  marks IssueRD pending, sampled at posedge Clock.
- IssueRD  in  ADDR_W  destination of the issued instruction.
- BusyRS  out  1  the RS register has a pending write.
- BusyRT  out  1  the RT register has a pending write.
- BusyMask  out  2**ADDR_W  raw busy bits, bit i = register i.

Behaviour:
- Reset asserted:
  - all registers become 0 and all busy bits become 0 immediately, without waiting for a clock edge;
  - ReadRS, ReadRT and BusyMask read 0 while Reset is held;
  - Reset overrides any write or issue in the same cycle.
- Write: at posedge, if RegWrite, Reg[RD] <= WriteData. Ignored when ZERO_REG=1 and RD=0.
- Reads are combinational and have zero latency.
  - ReadRS = 0 if ZERO_REG=1 and RS=0.
  - Otherwise, if BYPASS=1, RegWrite=1 and RD=RS: ReadRS = WriteData.
  - Otherwise ReadRS = Reg[RS].
  - ReadRT follows the same rules with RT.
- Busy bit update per register i at posedge, in priority order:
  - IssueValid and IssueRD=i: busy <= 1. Issue wins over a same-cycle writeback to i, because the new producer is still pending.
  - Else RegWrite and RD=i: busy <= 0.
  - Else busy holds its value.
  - When ZERO_REG=1, busy[0] is constant 0.
- Busy outputs are combinational.
  - BusyRS = busy[RS], except it is 0 when BYPASS=1, RegWrite=1 and RD=RS, since the data is being forwarded.
  - BusyRT follows the same rule with RT.
  - BusyMask shows the registered bits only, with no bypass.
- A write to a non-busy register is legal: the data is stored and the busy bit stays 0.
- RS=RT is legal; both ports return identical values.
- Index wrap-around cannot occur because depth = 2**ADDR_W; every index is valid.
- Reset asserted mid-issue: the pending state is lost. Upstream must flush the pipeline alongside Reset.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_DATA_W=16 and RF_ADDR_W=2;
  - function rf_depth(addr_w) returning 2**addr_w.
- One sub-module, rf_busy_table: the busy bit array, issue/writeback priority, and ZERO_REG masking.
- Storage, bypass mux and read ports stay in the top level.

Test Plan:
- Reset: write R1=16'hABCD; assert Reset between clock edges -> ReadRS(RS=1)=0 before the next edge; BusyMask=0.
- Write/read: write R2=16'h1234, RS=2, RT=2 -> next cycle ReadRS=ReadRT=16'h1234.
- Bypass: RegWrite=1, RD=3, WriteData=16'h00FF, RS=3 in the same cycle -> ReadRS=16'h00FF before the edge, and BusyRS=0 even with busy[3]=1.
  - With BYPASS=0 -> ReadRS shows the old value and BusyRS=1.
- Scoreboard: IssueValid, IssueRD=1 -> next cycle BusyMask=4'b0010 and BusyRS(RS=1)=1; RegWrite RD=1 -> next cycle BusyMask=0.
- Simultaneous: IssueRD=1 and RegWrite RD=1 at the same edge -> busy[1]=1 afterwards and R1 updated.
- ZERO_REG=1: write R0=16'hFFFF with IssueRD=0 -> ReadRS(RS=0)=0, BusyMask[0]=0; R1 unaffected.
